// File: rtl/game_master_fsm.sv
// Master sequencer for the VGA snake game: game state, committed travel direction,
// and the pausable, accelerating move tick that paces the snake datapath.
module game_master_fsm #(
  parameter logic [29:0] TICK_INIT   = 30'd29_999_999,
  parameter logic [29:0] TICK_STEP   = 30'd1_000_000,
  parameter logic [29:0] TICK_MIN    = 30'd4_999_999,
  parameter logic [7:0]  WIN_SCORE   = 8'h20,
  parameter logic [31:0] HOLD_CYCLES = 32'd89_999_999
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTNC,
  input  logic       Reached_Target,
  input  logic       Hit_wall_sig,
  input  logic       Hit_body_sig,
  input  logic       Hit_block_sig,
  input  logic [7:0] game_Score,
  output logic [1:0] MSM_State,
  output logic [1:0] Navigation_State,
  output logic       Move_Tick,
  output logic       Paused
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    FAIL = 2'b11
  } msm_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  msm_t        state, state_next;
  logic [1:0]  nav, nav_next;
  logic [1:0]  pending, pending_next;
  logic        move_tick, move_tick_next;
  logic        paused, paused_next;
  logic [29:0] period, period_next;
  logic [29:0] tick_cnt, tick_cnt_next;
  logic [31:0] hold_cnt, hold_cnt_next;

  logic       dir_press;
  logic [1:0] press_dir;
  logic       hit_any;
  logic       win_reached;
  logic       tick_due;

  assign dir_press   = BTNU | BTND | BTNL | BTNR;
  assign hit_any     = Hit_wall_sig | Hit_body_sig | Hit_block_sig;
  assign win_reached = (game_Score >= WIN_SCORE);
  assign tick_due    = !paused && (tick_cnt >= period);

  // Simultaneous direction pulses resolve Up > Down > Left > Right.
  always_comb begin
    press_dir = DIR_RIGHT;
    if (BTNU)      press_dir = DIR_UP;
    else if (BTND) press_dir = DIR_DOWN;
    else if (BTNL) press_dir = DIR_LEFT;
    else if (BTNR) press_dir = DIR_RIGHT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      nav       <= DIR_RIGHT;
      pending   <= DIR_RIGHT;
      move_tick <= 1'b0;
      paused    <= 1'b0;
      period    <= TICK_INIT;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_next;
      nav       <= nav_next;
      pending   <= pending_next;
      move_tick <= move_tick_next;
      paused    <= paused_next;
      period    <= period_next;
      tick_cnt  <= tick_cnt_next;
      hold_cnt  <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    nav_next       = nav;
    pending_next   = pending;
    move_tick_next = 1'b0;
    paused_next    = paused;
    period_next    = period;
    tick_cnt_next  = tick_cnt;
    hold_cnt_next  = hold_cnt;

    unique case (state)
      IDLE: begin
        tick_cnt_next = '0;
        hold_cnt_next = '0;
        paused_next   = 1'b0;
        period_next   = TICK_INIT;
        if (dir_press) begin
          state_next   = PLAY;
          nav_next     = press_dir;
          pending_next = press_dir;
        end else if (BTNC) begin
          state_next = PLAY;
        end
      end

      PLAY: begin
        if (hit_any || win_reached) begin
          state_next    = hit_any ? FAIL : WIN;
          paused_next   = 1'b0;
          period_next   = TICK_INIT;
          tick_cnt_next = '0;
          hold_cnt_next = '0;
        end else begin
          if (BTNC)
            paused_next = !paused;
          if (Reached_Target) begin
            if (period >= TICK_MIN + TICK_STEP)
              period_next = period - TICK_STEP;
            else
              period_next = TICK_MIN;
          end
          // Reversal is judged against the committed heading, so no sequence
          // of presses between ticks can fold the snake back onto itself.
          if (!paused && dir_press && (press_dir != (nav ^ 2'b01)))
            pending_next = press_dir;
          if (tick_due) begin
            move_tick_next = 1'b1;
            tick_cnt_next  = '0;
            nav_next       = pending_next;
          end else if (!paused) begin
            tick_cnt_next = tick_cnt + 30'd1;
          end
        end
      end

      WIN, FAIL: begin
        if (BTNC || (hold_cnt >= HOLD_CYCLES)) begin
          state_next    = IDLE;
          hold_cnt_next = '0;
          nav_next      = DIR_RIGHT;
          pending_next  = DIR_RIGHT;
        end else begin
          hold_cnt_next = hold_cnt + 32'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    MSM_State        = state;
    Navigation_State = nav;
    Move_Tick        = move_tick;
    Paused           = paused;
  end

endmodule

// File: tb/tb_game_master_fsm.sv
// Directed bench for game_master_fsm with shortened timing parameters.
module tb_game_master_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0, btnc = 1'b0;
  logic       tgt = 1'b0;
  logic       hit_wall = 1'b0, hit_body = 1'b0, hit_block = 1'b0;
  logic [7:0] score = 8'h00;
  logic [1:0] msm, nav;
  logic       tick, paused;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] B_U = 5'b10000;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b00010;

  always #5 clk = ~clk;

  game_master_fsm #(
    .TICK_INIT  (30'd9),
    .TICK_STEP  (30'd2),
    .TICK_MIN   (30'd3),
    .WIN_SCORE  (8'h03),
    .HOLD_CYCLES(32'd19)
  ) dut (
    .CLK             (clk),
    .RESET           (rst),
    .BTNU            (btnu),
    .BTND            (btnd),
    .BTNL            (btnl),
    .BTNR            (btnr),
    .BTNC            (btnc),
    .Reached_Target  (tgt),
    .Hit_wall_sig    (hit_wall),
    .Hit_body_sig    (hit_body),
    .Hit_block_sig   (hit_block),
    .game_Score      (score),
    .MSM_State       (msm),
    .Navigation_State(nav),
    .Move_Tick       (tick),
    .Paused          (paused)
  );

  typedef struct {
    logic       rst;
    logic [4:0] btn;
    logic [1:0] exp_state;
    logic [1:0] exp_nav;
    logic       exp_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [4:0] b, logic [1:0] s, logic [1:0] n, logic t);
    vec_t v;
    v.rst = r; v.btn = b; v.exp_state = s; v.exp_nav = n; v.exp_tick = t;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it, pulses then drop.
  task automatic step();
    @(posedge clk);
    #1;
    {btnu, btnd, btnl, btnr, btnc} = 5'b0;
    tgt = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst = v.rst;
    {btnu, btnd, btnl, btnr, btnc} = v.btn;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < budget);
    if (!tick) check_output({name, " timeout"}, 32'(tick), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (msm != 2'b00 && n < budget);
    if (msm != 2'b00) check_output({name, " timeout"}, 32'(msm), 32'd0);
  endtask

  initial begin
    int n;
    int tk;
    int exp_sp[4] = '{8, 6, 4, 4};

    vecs.push_back(mk(1'b1, 5'b0, 2'b00, 2'b11, 1'b0));
    vecs.push_back(mk(1'b0, 5'b0, 2'b00, 2'b11, 1'b0));
    vecs.push_back(mk(1'b0, B_R,  2'b01, 2'b11, 1'b0));
    repeat (9) vecs.push_back(mk(1'b0, 5'b0, 2'b01, 2'b11, 1'b0));
    vecs.push_back(mk(1'b0, 5'b0, 2'b01, 2'b11, 1'b1));
    vecs.push_back(mk(1'b0, B_U,  2'b01, 2'b11, 1'b0));
    vecs.push_back(mk(1'b0, B_D,  2'b01, 2'b11, 1'b0));
    vecs.push_back(mk(1'b0, B_L,  2'b01, 2'b11, 1'b0));
    repeat (6) vecs.push_back(mk(1'b0, 5'b0, 2'b01, 2'b11, 1'b0));
    vecs.push_back(mk(1'b0, 5'b0, 2'b01, 2'b01, 1'b1));
    vecs.push_back(mk(1'b0, B_U | B_L, 2'b01, 2'b01, 1'b0));
    repeat (8) vecs.push_back(mk(1'b0, 5'b0, 2'b01, 2'b01, 1'b0));
    vecs.push_back(mk(1'b0, 5'b0, 2'b01, 2'b01, 1'b1));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d state", i), 32'(msm), 32'(vecs[i].exp_state));
      check_output($sformatf("vec%0d nav", i), 32'(nav), 32'(vecs[i].exp_nav));
      check_output($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
      check_output($sformatf("vec%0d paused", i), 32'(paused), 32'd0);
    end

    // Speed-up: target pulse in each tick cycle shortens the following spacing.
    for (int k = 0; k < 4; k++) begin
      tgt = 1'b1;
      wait_tick($sformatf("speed%0d", k), 20, n);
      check_output($sformatf("speed%0d spacing", k), 32'(n), 32'(exp_sp[k]));
    end
    wait_tick("speed floor", 20, n);
    check_output("speed floor spacing", 32'(n), 32'd4);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("midgame reset state", 32'(msm), 32'd0);
    check_output("midgame reset nav", 32'(nav), 32'd3);
    check_output("midgame reset tick", 32'(tick), 32'd0);

    btnu = 1'b1;
    step();
    check_output("idle BTNU state", 32'(msm), 32'd1);
    check_output("idle BTNU nav", 32'(nav), 32'd0);
    wait_tick("period restored", 30, n);
    check_output("period restored spacing", 32'(n), 32'd10);

    // Pause at count 5, hold for 50 cycles with an ignored press, then resume.
    repeat (4) step();
    btnc = 1'b1;
    step();
    check_output("pause on", 32'(paused), 32'd1);
    tk = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) btnr = 1'b1;
      step();
      if (tick) tk++;
    end
    check_output("ticks while paused", 32'(tk), 32'd0);
    check_output("still paused", 32'(paused), 32'd1);
    btnc = 1'b1;
    step();
    check_output("pause off", 32'(paused), 32'd0);
    wait_tick("resume", 20, n);
    check_output("resume spacing", 32'(n), 32'd5);
    check_output("paused press ignored nav", 32'(nav), 32'd0);

    repeat (9) step();
    check_output("pre toggle tick", 32'(tick), 32'd0);
    btnc = 1'b1;
    step();
    check_output("tick in toggle cycle", 32'(tick), 32'd1);
    check_output("paused after toggle", 32'(paused), 32'd1);
    btnc = 1'b1;
    step();
    check_output("unpaused again", 32'(paused), 32'd0);

    score = 8'h02;
    step();
    check_output("score below win", 32'(msm), 32'd1);

    hit_body = 1'b1;
    score = 8'h03;
    step();
    check_output("hit beats win", 32'(msm), 32'd3);
    check_output("fail tick", 32'(tick), 32'd0);
    check_output("fail paused", 32'(paused), 32'd0);
    hit_body = 1'b0;
    score = 8'h00;
    wait_idle("fail hold", 40, n);
    check_output("fail hold length", 32'(n), 32'd20);
    check_output("fail return nav", 32'(nav), 32'd3);

    btnc = 1'b1;
    step();
    check_output("BTNC start state", 32'(msm), 32'd1);
    check_output("BTNC start nav", 32'(nav), 32'd3);
    score = 8'h03;
    step();
    check_output("win state", 32'(msm), 32'd2);
    score = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) btnl = 1'b1;
      step();
    end
    check_output("win hold state", 32'(msm), 32'd2);
    check_output("win press ignored nav", 32'(nav), 32'd3);
    check_output("win tick", 32'(tick), 32'd0);
    btnc = 1'b1;
    step();
    check_output("win ack state", 32'(msm), 32'd0);

    for (int j = 0; j < 2; j++) begin
      btnc = 1'b1;
      step();
      check_output($sformatf("restart%0d state", j), 32'(msm), 32'd1);
      if (j == 0) hit_wall = 1'b1;
      else        hit_block = 1'b1;
      step();
      check_output($sformatf("hit%0d state", j), 32'(msm), 32'd3);
      hit_wall = 1'b0;
      hit_block = 1'b0;
      wait_idle($sformatf("hit%0d hold", j), 40, n);
      check_output($sformatf("hit%0d hold length", j), 32'(n), 32'd20);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
